mod_n_toggle_counter: RTL and testbench

//  Synchronous modulo-N up/down counter built from per-bit toggle stages; consumes the

---
 rtl/mod_n_toggle_counter_pkg.sv | 15 +
 rtl/mod_n_toggle_counter_t_stage.sv | 23 ++
 rtl/mod_n_toggle_counter.sv | 90 +++++++++
 tb/tb_mod_n_toggle_counter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod_n_toggle_counter_pkg.sv
// Shared constants and helpers for the toggle-stage counter family.
// Cascaded digit counters import this package.
package mod_n_toggle_counter_pkg;

  localparam int   DEF_WIDTH   = 4;
  localparam int   DEF_MODULUS = 10;
  localparam logic DIR_UP      = 1'b1;
  localparam logic DIR_DOWN    = 1'b0;

  // Picks the terminal condition for the active direction (max going up, zero going down)
  function automatic logic dir_hit(input logic up, input logic at_max, input logic at_zero);
    return (up == DIR_DOWN) ? at_zero : at_max;
  endfunction

endpackage

// File: rtl/mod_n_toggle_counter_t_stage.sv
// One-bit toggle flop: q flips on every rising edge where t is high.
// Asynchronous active-low reset clears it to 0.
module t_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  logic q_r;

  // Toggle register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 1'b0;
    end else begin
      q_r <= q_r ^ t;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mod_n_toggle_counter.sv
// Modulo-N up/down counter with load, cascade terminal count and wrap/load-error pulses.
// The count state lives only in toggle stages, driven by the mask q ^ q_next.
module mod_n_toggle_counter
  import mod_n_toggle_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH:0] zero_v = (WIDTH+1)'(0);
  localparam logic [WIDTH:0] one_v  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] mod_v  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] last_v = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] t_mask_s;
  logic [WIDTH:0]   q_ext_s;
  logic [WIDTH:0]   load_ext_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic             load_oor_s;
  logic             wrap_r;
  logic             load_err_r;

  // Next-value selection in WIDTH+1 bits; load clamps out-of-range values to MODULUS-1
  always_comb begin
    q_ext_s    = {1'b0, q_s};
    load_ext_s = {1'b0, load_val};
    at_max_s   = (q_ext_s == last_v);
    at_zero_s  = (q_ext_s == zero_v);
    load_oor_s = (load_ext_s >= mod_v);
    q_next_s   = q_s;
    if (load) begin
      q_next_s = load_oor_s ? WIDTH'(last_v) : load_val;
    end else if (en) begin
      if (up == DIR_UP) begin
        q_next_s = at_max_s ? WIDTH'(zero_v) : WIDTH'(q_ext_s + one_v);
      end else begin
        q_next_s = at_zero_s ? WIDTH'(last_v) : WIDTH'(q_ext_s - one_v);
      end
    end else begin
      q_next_s = q_s;
    end
    t_mask_s = q_s ^ q_next_s;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    t_stage u_stage (
      .clk   (clk),
      .rst_n (reset),
      .t     (t_mask_s[i]),
      .q     (q_s[i])
    );
  end

  // Event pulses, aligned with q showing the wrapped or clamped value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else if (load) begin
      wrap_r     <= 1'b0;
      load_err_r <= load_oor_s;
    end else if (en) begin
      wrap_r     <= dir_hit(up, at_max_s, at_zero_s);
      load_err_r <= 1'b0;
    end else begin
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end
  end

  assign q        = q_s;
  assign tc       = en & dir_hit(up, at_max_s, at_zero_s);
  assign wrap     = wrap_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_mod_n_toggle_counter.sv
// Directed self-checking bench: single decade counter plus a two-digit cascade.
module tb_mod_n_toggle_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap, load_err;

  logic       cen, cup, cload;
  logic [3:0] cval;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_err, hi_err;
  logic       hi_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign hi_en = cen & lo_tc;

  mod_n_toggle_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  mod_n_toggle_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .reset(reset), .en(cen), .up(cup), .load(cload), .load_val(cval),
    .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_err)
  );

  mod_n_toggle_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .reset(reset), .en(hi_en), .up(cup), .load(cload), .load_val(cval),
    .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_err)
  );

  task automatic test_reset;
    #2;
    checks++;
    if (q !== 4'd0 || wrap !== 1'b0 || load_err !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial: q=%0d wrap=%b load_err=%b tc=%b required q=0 wrap=0 load_err=0 tc=0",
               q, wrap, load_err, tc);
    end
    #1 reset = 1'b1; en = 1'b1; up = 1'b1;
    repeat (7) begin
      @(posedge clk); #1;
    end
    checks++;
    if (q !== 4'd7) begin
      failures++;
      $display("FAIL count_to_7: q=%0d required 7", q);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 4'd0 || wrap !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: q=%0d wrap=%b load_err=%b required q=0 wrap=0 load_err=0",
               q, wrap, load_err);
    end
  endtask

  task automatic test_count_up;
    logic [3:0] exp_q;
    en = 1'b1; up = 1'b1;
    #1 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_q = 4'((i + 1) % 10);
      @(posedge clk); #1;
      checks++;
      if (q !== exp_q || wrap !== (exp_q == 4'd0) || tc !== (exp_q == 4'd9) || q >= 4'd10) begin
        failures++;
        $display("FAIL count_up[%0d]: q=%0d wrap=%b tc=%b required q=%0d wrap=%b tc=%b",
                 i, q, wrap, tc, exp_q, (exp_q == 4'd0), (exp_q == 4'd9));
      end
    end
  endtask

  task automatic test_count_down;
    logic [3:0] exp_q [0:2];
    logic       exp_w [0:2];
    exp_q = '{4'd9, 4'd8, 4'd7};
    exp_w = '{1'b1, 1'b0, 1'b0};
    en = 1'b0; up = 1'b0; load = 1'b1; load_val = 4'd0;
    @(posedge clk); #1;
    load = 1'b0;
    checks++;
    if (q !== 4'd0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL down_start: q=%0d tc=%b required q=0 tc=0", q, tc);
    end
    en = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      failures++;
      $display("FAIL down_tc_at_zero: tc=%b required 1", tc);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q !== exp_q[i] || wrap !== exp_w[i] || tc !== 1'b0) begin
        failures++;
        $display("FAIL count_down[%0d]: q=%0d wrap=%b tc=%b required q=%0d wrap=%b tc=0",
                 i, q, wrap, tc, exp_q[i], exp_w[i]);
      end
    end
    up = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd8 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL dir_change: q=%0d wrap=%b required q=8 wrap=0", q, wrap);
    end
  endtask

  task automatic test_load;
    logic [3:0] vals  [0:5];
    logic       ens   [0:5];
    logic [3:0] exp_q [0:5];
    logic       exp_e [0:5];
    vals  = '{4'd13, 4'd4, 4'd10, 4'd9, 4'd0, 4'd15};
    ens   = '{1'b0,  1'b1, 1'b1,  1'b0, 1'b1, 1'b0};
    exp_q = '{4'd9,  4'd4, 4'd9,  4'd9, 4'd0, 4'd9};
    exp_e = '{1'b1,  1'b0, 1'b1,  1'b0, 1'b0, 1'b1};
    up = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load = 1'b1; load_val = vals[i]; en = ens[i];
      @(posedge clk); #1;
      checks++;
      if (q !== exp_q[i] || load_err !== exp_e[i] || wrap !== 1'b0) begin
        failures++;
        $display("FAIL load[%0d] val=%0d: q=%0d load_err=%b wrap=%b required q=%0d load_err=%b wrap=0",
                 i, vals[i], q, load_err, wrap, exp_q[i], exp_e[i]);
      end
    end
    load = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd9 || load_err !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load_hold: q=%0d load_err=%b wrap=%b required q=9 load_err=0 wrap=0",
               q, load_err, wrap);
    end
  endtask

  task automatic test_cascade;
    logic [3:0] exp_lo, exp_hi;
    int lo_wraps = 0;
    int hi_wraps = 0;
    checks++;
    if (lo_q !== 4'd0 || hi_q !== 4'd0) begin
      failures++;
      $display("FAIL cascade_start: lo=%0d hi=%0d required 0 0", lo_q, hi_q);
    end
    cup = 1'b1; cen = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      exp_lo = 4'(n % 10);
      exp_hi = 4'((n / 10) % 10);
      @(posedge clk); #1;
      if (lo_wrap === 1'b1) lo_wraps++;
      if (hi_wrap === 1'b1) hi_wraps++;
      checks++;
      if (lo_q !== exp_lo || hi_q !== exp_hi || lo_wrap !== (exp_lo == 4'd0)) begin
        failures++;
        $display("FAIL cascade[%0d]: lo=%0d hi=%0d lo_wrap=%b required lo=%0d hi=%0d lo_wrap=%b",
                 n, lo_q, hi_q, lo_wrap, exp_lo, exp_hi, (exp_lo == 4'd0));
      end
    end
    checks++;
    if (lo_wraps != 10 || hi_wraps != 1) begin
      failures++;
      $display("FAIL cascade_wraps: lo_wraps=%0d hi_wraps=%0d required 10 1", lo_wraps, hi_wraps);
    end
    cen = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (lo_q !== 4'd0 || hi_q !== 4'd0 || hi_wrap !== 1'b0 || lo_wrap !== 1'b0) begin
      failures++;
      $display("FAIL cascade_hold: lo=%0d hi=%0d lo_wrap=%b hi_wrap=%b required 0 0 0 0",
               lo_q, hi_q, lo_wrap, hi_wrap);
    end
  endtask

  task automatic test_reset_mid;
    load = 1'b1; load_val = 4'd4; en = 1'b0; up = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd5) begin
      failures++;
      $display("FAIL mid_pre: q=%0d required 5", q);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (q !== 4'd0 || wrap !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: q=%0d wrap=%b tc=%b required q=0 wrap=0 tc=0", q, wrap, tc);
    end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL mid_release: q=%0d wrap=%b required q=1 wrap=0", q, wrap);
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    cen = 1'b0; cup = 1'b1; cload = 1'b0; cval = 4'd0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_cascade();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
